ifetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the immediate extender in the RV32I core.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small in-order queue and presents the head instruction, its PC and the pre-decoded 3-bit Extend_Sel to decode.
- Supports a single-cycle redirect (branch/jump) that flushes the queue and discards stale responses.

---
 rtl/ifetch_queue_if.sv | 35 +++
 rtl/ifetch_queue.sv | 123 ++++++++++++
 tb/tb_ifetch_queue.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect, and decode-side handshake.
// Inst_Illegal exists only when IFETCH_ILLEGAL_DETECT_EN is defined.
interface ifetch_queue_if;
    logic        Imem_Req_Valid;
    logic        Imem_Req_Ready;
    logic [31:0] Imem_Req_Addr;
    logic        Imem_Rsp_Valid;
    logic [31:0] Imem_Rsp_Data;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Inst_Out;
    logic [31:0] Inst_PC;
    logic [2:0]  Extend_Sel;
`ifdef IFETCH_ILLEGAL_DETECT_EN
    logic        Inst_Illegal;
`endif

    modport master (
`ifdef IFETCH_ILLEGAL_DETECT_EN
        output Inst_Illegal,
`endif
        output Imem_Req_Valid, Imem_Req_Addr, Inst_Valid, Inst_Out, Inst_PC, Extend_Sel,
        input  Imem_Req_Ready, Imem_Rsp_Valid, Imem_Rsp_Data, Redirect, Redirect_PC, Inst_Ready
    );

    modport slave (
`ifdef IFETCH_ILLEGAL_DETECT_EN
        input  Inst_Illegal,
`endif
        input  Imem_Req_Valid, Imem_Req_Addr, Inst_Valid, Inst_Out, Inst_PC, Extend_Sel,
        output Imem_Req_Ready, Imem_Rsp_Valid, Imem_Rsp_Data, Redirect, Redirect_PC, Inst_Ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited word fetch, in-order buffer, redirect flush with stale-response drop.
// Optional macro IFETCH_ILLEGAL_DETECT_EN adds Inst_Illegal for non-RV32I opcodes at the queue head.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic            Clk,
    input logic            Rst_n,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [31:0]   word_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          req_valid, req_fire, rsp_keep, push, pop, inst_valid;
    logic [CW:0]   credit_used;
    logic [31:0]   head_word, head_pc;
    logic [6:0]    opcode;
    logic [2:0]    ext_dec;

    function automatic logic [2:0] ext_of(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: ext_of = 3'b000;
            7'b0100011:                         ext_of = 3'b001;
            7'b1100011:                         ext_of = 3'b010;
            7'b0110111, 7'b0010111:             ext_of = 3'b011;
            7'b1101111:                         ext_of = 3'b100;
            default:                            ext_of = 3'b111;
        endcase
    endfunction

    // Credits cover both buffered words and words still in flight, so a response always has a slot.
    always_comb begin
        credit_used = {1'b0, count_q} + {1'b0, outst_q};
        inst_valid  = (count_q != '0);
        req_valid   = Rst_n && !bus.Redirect && (credit_used < (CW+1)'(DEPTH));
        req_fire    = req_valid && bus.Imem_Req_Ready;
        rsp_keep    = bus.Imem_Rsp_Valid && (drop_q == '0);
        push        = rsp_keep && !bus.Redirect;
        pop         = inst_valid && bus.Inst_Ready && !bus.Redirect;
    end

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        outst_d  = outst_q + CW'(req_fire) - CW'(bus.Imem_Rsp_Valid);
        drop_d   = drop_q;
        if (req_fire)
            pc_d = pc_q + 32'd4;
        if (rsp_keep)
            rsp_pc_d = rsp_pc_q + 32'd4;
        if (bus.Imem_Rsp_Valid && (drop_q != '0))
            drop_d = drop_q - CW'(1);
        // Every request still in flight after this cycle belongs to the abandoned stream.
        if (bus.Redirect) begin
            pc_d     = bus.Redirect_PC & ~32'h3;
            rsp_pc_d = bus.Redirect_PC & ~32'h3;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = outst_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= bus.Imem_Rsp_Data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    always_comb begin
        head_word = inst_valid ? word_mem[rd_ptr_q] : 32'h0;
        head_pc   = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;
        opcode    = head_word[6:0];
        ext_dec   = inst_valid ? ext_of(opcode) : 3'b000;
    end

    assign bus.Imem_Req_Valid = req_valid;
    assign bus.Imem_Req_Addr  = pc_q;
    assign bus.Inst_Valid     = inst_valid;
    assign bus.Inst_Out       = head_word;
    assign bus.Inst_PC        = head_pc;
    assign bus.Extend_Sel     = ext_dec;

`ifdef IFETCH_ILLEGAL_DETECT_EN
    logic op_legal;
    always_comb begin
        op_legal = (ext_dec != 3'b111) || (opcode == 7'b0110011) ||
                   (opcode == 7'b0001111) || (opcode == 7'b1110011);
    end
    assign bus.Inst_Illegal = inst_valid && ((head_word[1:0] != 2'b11) || !op_legal);
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a memory model predicts each kept response, a separate monitor checks the head.
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if bus();
    ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (.Clk(clk), .Rst_n(rst_n), .bus(bus));

    typedef struct { logic [31:0] pc; logic stale; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; logic [2:0] ext; logic ill; } exp_t;

    // Memory image repeats every 8 words; Extend_Sel / illegal values worked out by hand.
    logic [31:0] tbl_word [8] = '{32'h00500093, 32'h00112023, 32'hFE000EE3, 32'h000012B7,
                                  32'h0080006F, 32'h002081B3, 32'h00000000, 32'h00002083};
    logic [2:0]  tbl_ext  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b111, 3'b000};
    logic        tbl_ill  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    pend_t       pend[$];
    exp_t        sb[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, acc_cnt = 0, mem_lat = 1;
    logic [31:0] exp_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.Redirect    = 1'b1;
        bus.Redirect_PC = pc;
        step(1);
        bus.Redirect    = 1'b0;
    endtask

    // Memory model: accepts requests, returns words in order after mem_lat cycles, feeds the scoreboard.
    initial begin
        pend_t e;
        logic        live, cur_valid, cur_stale;
        logic [31:0] cur_pc;
        exp_t        x;
        cur_valid = 1'b0; cur_stale = 1'b0; cur_pc = '0;
        bus.Imem_Rsp_Valid = 1'b0;
        bus.Imem_Rsp_Data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            live = rst_n;
            if (!rst_n) begin
                pend.delete();
                sb.delete();
                cur_valid = 1'b0;
                exp_addr  = 32'h0;
            end else begin
                if (bus.Imem_Req_Valid && bus.Imem_Req_Ready) begin
                    chk("req_addr", bus.Imem_Req_Addr, exp_addr);
                    acc_cnt++;
                    e.pc = exp_addr; e.stale = 1'b0; e.due = cyc + mem_lat - 1;
                    pend.push_back(e);
                    exp_addr = exp_addr + 32'd4;
                end
                if (bus.Redirect) begin
                    foreach (pend[i]) pend[i].stale = 1'b1;
                    sb.delete();
                    exp_addr = {bus.Redirect_PC[31:2], 2'b00};
                end else if (cur_valid && !cur_stale) begin
                    x.pc   = cur_pc;
                    x.word = tbl_word[cur_pc[4:2]];
                    x.ext  = tbl_ext[cur_pc[4:2]];
                    x.ill  = tbl_ill[cur_pc[4:2]];
                    sb.push_back(x);
                end
            end
            @(posedge clk);
            #1;
            cur_valid = 1'b0;
            if (live && pend.size() > 0 && pend[0].due <= cyc) begin
                e = pend.pop_front();
                cur_valid = 1'b1; cur_pc = e.pc; cur_stale = e.stale;
            end
            bus.Imem_Rsp_Valid = cur_valid;
            bus.Imem_Rsp_Data  = cur_valid ? tbl_word[cur_pc[4:2]] : 32'hDEAD_BEEF;
        end
    end

    // Monitor: compares the presented head against the scoreboard front, pops on consumption.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !bus.Redirect && bus.Inst_Valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_inst_pc", bus.Inst_PC, 32'hFFFF_FFFF);
                end else begin
                    chk("inst_pc", bus.Inst_PC, sb[0].pc);
                    chk("inst_out", bus.Inst_Out, sb[0].word);
                    chk("extend_sel", 32'(bus.Extend_Sel), 32'(sb[0].ext));
`ifdef IFETCH_ILLEGAL_DETECT_EN
                    chk("inst_illegal", 32'(bus.Inst_Illegal), 32'(sb[0].ill));
`endif
                    if (bus.Inst_Ready) begin
                        $display("inst pc=%h word=%h ext=%b", bus.Inst_PC, bus.Inst_Out, bus.Extend_Sel);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int a0, n;
        bus.Imem_Req_Ready = 1'b1;
        bus.Inst_Ready     = 1'b1;
        bus.Redirect       = 1'b0;
        bus.Redirect_PC    = '0;

        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.Imem_Req_Valid), 32'h0);
        chk("rst_inst_valid", 32'(bus.Inst_Valid), 32'h0);
        chk("rst_inst_out", bus.Inst_Out, 32'h0);
        chk("rst_inst_pc", bus.Inst_PC, 32'h0);
        chk("rst_extend_sel", 32'(bus.Extend_Sel), 32'h0);
`ifdef IFETCH_ILLEGAL_DETECT_EN
        chk("rst_inst_illegal", 32'(bus.Inst_Illegal), 32'h0);
`endif
        step(1);
        rst_n = 1'b1;

        // Streaming from 0x0: covers every Extend_Sel encoding in the table
        step(24);

        // Decode stalled: only DEPTH requests, then one credit per pop
        bus.Inst_Ready = 1'b0;
        do_redirect(32'h0000_0200);
        a0 = acc_cnt;
        step(10);
        chk("stall_accepts", 32'(acc_cnt - a0), 32'd2);
        @(negedge clk);
        chk("stall_req_valid", 32'(bus.Imem_Req_Valid), 32'h0);
        step(1);
        bus.Inst_Ready = 1'b1;
        step(1);
        bus.Inst_Ready = 1'b0;
        @(negedge clk);
        chk("credit_after_pop", 32'(bus.Imem_Req_Valid), 32'h1);
        step(5);
        chk("accepts_after_pop", 32'(acc_cnt - a0), 32'd3);

        // Redirect with two requests in flight; both late words must vanish
        bus.Inst_Ready = 1'b1;
        mem_lat = 3;
        do_redirect(32'h0000_0040);
        n = 0;
        while (pend.size() != 2 && n < 50) begin step(1); n++; end
        chk("two_outstanding", 32'(pend.size()), 32'd2);
        do_redirect(32'h0000_0103);
        n = 0;
        @(negedge clk);
        while (!bus.Imem_Req_Valid && n < 50) begin @(negedge clk); n++; end
        chk("redir_req_valid", 32'(bus.Imem_Req_Valid), 32'h1);
        chk("redir_req_addr", bus.Imem_Req_Addr, 32'h0000_0100);
        n = 0;
        while (!bus.Inst_Valid && n < 50) begin @(negedge clk); n++; end
        chk("redir_first_pc", bus.Inst_PC, 32'h0000_0100);

        // Request held while memory stalls; PC moves only on acceptance
        step(1);
        mem_lat = 1;
        bus.Imem_Req_Ready = 1'b0;
        step(6);
        do_redirect(32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_req_valid", 32'(bus.Imem_Req_Valid), 32'h1);
            chk("hold_req_addr", bus.Imem_Req_Addr, 32'h0000_0300);
            step(1);
        end
        bus.Imem_Req_Ready = 1'b1;
        step(1);
        @(negedge clk);
        chk("addr_after_accept", bus.Imem_Req_Addr, 32'h0000_0304);

        // Wrap past the top of the address space; word 0 at 0xFFFFFFF8 is illegal
        step(1);
        do_redirect(32'hFFFF_FFF4);
        step(14);

        // Drain: stop fetching, let decode empty the queue
        bus.Imem_Req_Ready = 1'b0;
        step(12);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("responses_drained", 32'(pend.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
